// File: rtl/game_io_pkg.sv
// Shared types and helpers for the game's keypad / display I/O blocks.
package game_io_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} scan_state_e;

   localparam logic [3:0] COL_RESET = 4'b1110;
   localparam int         KEY_W     = 4;

   // Lowest set bit wins; all-zero input maps to 3 (callers gate with a hit flag).
   function automatic logic [1:0] prio_enc4(input logic [3:0] v);
      logic [1:0] idx;
      if (v[0])      idx = 2'd0;
      else if (v[1]) idx = 2'd1;
      else if (v[2]) idx = 2'd2;
      else           idx = 2'd3;
      return idx;
   endfunction

   function automatic logic [3:0] rot_left4(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the decoded key outputs seen by the game logic.
interface keypad_scanner_if;
   import game_io_pkg::*;

   logic [3:0]       row_in;
   logic [3:0]       col_sel;
   logic [KEY_W-1:0] key_code;
   logic             key_valid;
   logic             key_held;

   modport master (
      input  row_in,
      output col_sel, key_code, key_valid, key_held
   );

   modport slave (
      output row_in,
      input  col_sel, key_code, key_valid, key_held
   );

endinterface

// File: rtl/keypad_scanner_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks, sets the column dwell.
module scan_tick_gen #(
   parameter int SCAN_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic o_tick
);

   localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TICK_W-1:0] LAST = TICK_W'(SCAN_DIV - 1);

   logic [TICK_W-1:0] r_cnt;
   logic              w_tick;

   assign w_tick = (r_cnt == LAST);
   assign o_tick = w_tick;

   always_ff @(posedge clk) begin
      if (!reset)      r_cnt <= '0;
      else if (w_tick) r_cnt <= '0;
      else             r_cnt <= r_cnt + TICK_W'(1);
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column rotation, row sync, debounce and one code per press.
module keypad_scanner
   import game_io_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic             clk,
   input  logic             reset,
   keypad_scanner_if.master kp
);

   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_SCANS);

   logic             w_tick;
   logic [3:0]       r_sync1, r_sync2;
   scan_state_e      r_state, w_state;
   logic [3:0]       r_col_sel, w_col_sel;
   logic [1:0]       r_cand_row, w_cand_row;
   logic [1:0]       r_cand_col, w_cand_col;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic [KEY_W-1:0] r_key_code, w_key_code;
   logic             r_key_valid, w_key_valid;
   logic             r_key_held, w_key_held;

   logic [3:0]       w_rows;
   logic             w_hit;
   logic [1:0]       w_row_enc;
   logic [1:0]       w_col_idx;
   logic [CNT_W-1:0] w_cnt_inc;

   scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .o_tick (w_tick)
   );

   // Rows are asynchronous to clk; only the second flop is ever used.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
      end else begin
         r_sync1 <= kp.row_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rows    = ~r_sync2;
   assign w_hit     = |w_rows;
   assign w_row_enc = prio_enc4(w_rows);
   assign w_col_idx = prio_enc4(~r_col_sel);
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   always_comb begin
      w_state     = r_state;
      w_col_sel   = r_col_sel;
      w_cand_row  = r_cand_row;
      w_cand_col  = r_cand_col;
      w_cnt       = r_cnt;
      w_key_code  = r_key_code;
      w_key_valid = 1'b0;
      w_key_held  = r_key_held;

      if (w_tick) begin
         unique case (r_state)
            SCAN: begin
               if (w_hit) begin
                  w_cand_row = w_row_enc;
                  w_cand_col = w_col_idx;
                  if (DEBOUNCE_SCANS == 1) begin
                     w_state     = PRESSED;
                     w_key_code  = {w_row_enc, w_col_idx};
                     w_key_valid = 1'b1;
                     w_key_held  = 1'b1;
                     w_cnt       = '0;
                  end else begin
                     w_state = DEBOUNCE;
                     w_cnt   = CNT_W'(1);
                  end
               end else begin
                  w_col_sel = rot_left4(r_col_sel);
               end
            end
            DEBOUNCE: begin
               if (w_hit && (w_row_enc == r_cand_row)) begin
                  if (w_cnt_inc == DB_LAST) begin
                     w_state     = PRESSED;
                     w_key_code  = {r_cand_row, r_cand_col};
                     w_key_valid = 1'b1;
                     w_key_held  = 1'b1;
                     w_cnt       = '0;
                  end else begin
                     w_cnt = w_cnt_inc;
                  end
               end else begin
                  w_state   = SCAN;
                  w_cnt     = '0;
                  w_col_sel = rot_left4(r_col_sel);
               end
            end
            PRESSED: begin
               // Count is reused as the release counter; any row in the frozen column keeps it held.
               if (w_hit) begin
                  w_cnt = '0;
               end else if (w_cnt_inc == DB_LAST) begin
                  w_state    = SCAN;
                  w_key_held = 1'b0;
                  w_cnt      = '0;
                  w_col_sel  = rot_left4(r_col_sel);
               end else begin
                  w_cnt = w_cnt_inc;
               end
            end
            default: begin
               w_state = SCAN;
               w_cnt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= SCAN;
         r_col_sel   <= COL_RESET;
         r_cand_row  <= '0;
         r_cand_col  <= '0;
         r_cnt       <= '0;
         r_key_code  <= '0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_col_sel   <= w_col_sel;
         r_cand_row  <= w_cand_row;
         r_cand_col  <= w_cand_col;
         r_cnt       <= w_cnt;
         r_key_code  <= w_key_code;
         r_key_valid <= w_key_valid;
         r_key_held  <= w_key_held;
      end
   end

   assign kp.col_sel   = r_col_sel;
   assign kp.key_code  = r_key_code;
   assign kp.key_valid = r_key_valid;
   assign kp.key_held  = r_key_held;

endmodule
